// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs, stage controls out.
// master = pipeline side, slave = hazard_controller.
interface hazard_controller_if;
  logic [2:0] id_sr1;
  logic [2:0] id_sr2;
  logic       id_uses_sr1;
  logic       id_uses_sr2;
  logic       ex_mem_read;
  logic [2:0] ex_dest;
  logic       ex_reg_write;
  logic       imem_resp;
  logic       mem_access;
  logic       dmem_resp;
  logic       mem_br_taken;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       bubble_ex;
  logic       bubble_id;
  logic       bubble_wb;
  logic       flush;
  logic       hang_err;

  modport master (
    output id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
    output ex_mem_read, ex_dest, ex_reg_write,
    output imem_resp, mem_access, dmem_resp, mem_br_taken,
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  bubble_ex, bubble_id, bubble_wb, flush, hang_err
  );

  modport slave (
    input  id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
    input  ex_mem_read, ex_dest, ex_reg_write,
    input  imem_resp, mem_access, dmem_resp, mem_br_taken,
    output stall_if, stall_id, stall_ex, stall_mem,
    output bubble_ex, bubble_id, bubble_wb, flush, hang_err
  );
endinterface

// File: rtl/hazard_controller.sv
// LC-3b 5-stage hazard controller: stalls, bubbles, flush, miss watchdog.
// Define HAZARD_PERF_EN to build the performance counters.
module hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hazard_controller_if.slave   hz,
  output logic [CNT_WIDTH-1:0] perf_dstall,
  output logic [CNT_WIDTH-1:0] perf_istall,
  output logic [CNT_WIDTH-1:0] perf_loaduse,
  output logic [CNT_WIDTH-1:0] perf_flush
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_t;

  localparam int unsigned WD_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TIMEOUT_CYCLES - 1);

  state_t          fsm;
  logic            squash_pend;
  logic [WD_W-1:0] wd_cnt;
  logic            hang_err;

  logic dstall;
  logic istall;
  logic luse;
  logic src1_hit;
  logic src2_hit;

  logic sel_d;
  logic sel_br;
  logic sel_lu;
  logic sel_sq;
  logic sel_i;

  logic stall_if;
  logic stall_id;
  logic stall_ex;
  logic stall_mem;
  logic bubble_ex;
  logic bubble_id;
  logic bubble_wb;
  logic flush;

  assign dstall   = hz.mem_access & ~hz.dmem_resp;
  assign istall   = ~hz.imem_resp;
  assign src1_hit = hz.id_uses_sr1 & (hz.id_sr1 == hz.ex_dest);
  assign src2_hit = hz.id_uses_sr2 & (hz.id_sr2 == hz.ex_dest);
  assign luse     = hz.ex_mem_read & hz.ex_reg_write
                  & (src1_hit | src2_hit);

  // One-hot action select; a held redirect waits out a D-miss,
  // a load-use bubble outranks both squash and plain I-miss.
  assign sel_d  = dstall;
  assign sel_br = hz.mem_br_taken & ~dstall;
  assign sel_lu = luse & ~dstall & ~hz.mem_br_taken;
  assign sel_sq = squash_pend & ~dstall
                & ~hz.mem_br_taken & ~luse;
  assign sel_i  = istall & ~dstall & ~hz.mem_br_taken
                & ~luse & ~squash_pend;

  // Mealy stage controls, forced low while reset is asserted.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    bubble_id = 1'b0;
    bubble_wb = 1'b0;
    flush     = 1'b0;
    if (reset_n) begin
      unique case (1'b1)
        sel_d: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          bubble_wb = 1'b1;
        end
        sel_br: begin
          flush = 1'b1;
        end
        sel_lu: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
        sel_sq: begin
          stall_if  = ~hz.imem_resp;
          bubble_id = 1'b1;
        end
        sel_i: begin
          stall_if  = 1'b1;
          bubble_id = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign hz.stall_if  = stall_if;
  assign hz.stall_id  = stall_id;
  assign hz.stall_ex  = stall_ex;
  assign hz.stall_mem = stall_mem;
  assign hz.bubble_ex = bubble_ex;
  assign hz.bubble_id = bubble_id;
  assign hz.bubble_wb = bubble_wb;
  assign hz.flush     = flush;
  assign hz.hang_err  = hang_err;

  // Miss state, pending fetch squash and the sticky watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm         <= RUN;
      squash_pend <= 1'b0;
      wd_cnt      <= '0;
      hang_err    <= 1'b0;
    end else begin
      if (dstall) begin
        fsm <= DWAIT;
      end else if (istall) begin
        fsm <= IWAIT;
      end else begin
        fsm <= RUN;
      end

      if (sel_br) begin
        if (istall) begin
          squash_pend <= 1'b1;
        end
      end else if (sel_sq && hz.imem_resp) begin
        squash_pend <= 1'b0;
      end

      if (fsm == RUN) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
        if (wd_cnt == WD_MAX) begin
          hang_err <= 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_dstall;
  logic [CNT_WIDTH-1:0] cnt_istall;
  logic [CNT_WIDTH-1:0] cnt_loaduse;
  logic [CNT_WIDTH-1:0] cnt_flush;

  // Free-running event counters, wrapping at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_dstall  <= '0;
      cnt_istall  <= '0;
      cnt_loaduse <= '0;
      cnt_flush   <= '0;
    end else begin
      if (dstall) begin
        cnt_dstall <= cnt_dstall + CNT_WIDTH'(1);
      end
      if (istall && !dstall) begin
        cnt_istall <= cnt_istall + CNT_WIDTH'(1);
      end
      if (sel_lu) begin
        cnt_loaduse <= cnt_loaduse + CNT_WIDTH'(1);
      end
      if (sel_br) begin
        cnt_flush <= cnt_flush + CNT_WIDTH'(1);
      end
    end
  end

  assign perf_dstall  = cnt_dstall;
  assign perf_istall  = cnt_istall;
  assign perf_loaduse = cnt_loaduse;
  assign perf_flush   = cnt_flush;
`else
  assign perf_dstall  = '0;
  assign perf_istall  = '0;
  assign perf_loaduse = '0;
  assign perf_flush   = '0;
`endif

endmodule
